// File: rtl/uart_tx_sched.sv
// Two-requester byte scheduler that feeds a Wishbone UART: polls STATUS for
// TX-ready, then writes each byte to DATA, with packet locking and ack timeout.
module uart_tx_sched #(
  parameter logic [7:0] UART_DATA_ADDR = 8'h00,
  parameter logic [7:0] UART_STAT_ADDR = 8'h04,
  parameter int         TX_RDY_BIT     = 1,
  parameter int         ACK_TIMEOUT    = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req0_valid,
  input  logic [7:0]  req0_data,
  input  logic        req0_last,
  output logic        req0_ready,
  input  logic        req1_valid,
  input  logic [7:0]  req1_data,
  input  logic        req1_last,
  output logic        req1_ready,
  output logic [7:0]  wbm_addr,
  output logic [31:0] wbm_dat_o,
  input  logic [31:0] wbm_dat_i,
  output logic        wbm_we,
  output logic [3:0]  wbm_sel,
  output logic        wbm_stb,
  input  logic        wbm_ack,
  output logic        busy,
  output logic        grant_id,
  output logic        err,
  input  logic        err_clr,
  output logic [15:0] tx_count
);

  localparam int TMO_W = $clog2(ACK_TIMEOUT) + 1;

  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_POLL, S_WRITE, S_GAP} state_t;

  state_t            r_state;
  state_t            r_gap_next;
  logic              r_grant;
  logic              r_prio;
  logic              r_stb;
  logic              r_we;
  logic [3:0]        r_sel;
  logic [7:0]        r_addr;
  logic [31:0]       r_dat_o;
  logic [7:0]        r_byte;
  logic              r_last;
  logic              r_err;
  logic [15:0]       r_tx_count;
  logic [TMO_W-1:0]  r_tmo;

  logic       w_in_bus;
  logic       w_ack;
  logic       w_timeout;
  logic       w_hs0;
  logic       w_hs1;
  logic [7:0] w_req_data;
  logic       w_req_last;
  logic       w_unused;

  // Only the ack cycle of a live strobe counts; everything else on the bus is ignored.
  assign w_in_bus   = ((r_state == S_POLL) || (r_state == S_WRITE)) && r_stb;
  assign w_ack      = w_in_bus && wbm_ack;
  assign w_timeout  = w_in_bus && !wbm_ack && (r_tmo == TMO_W'(ACK_TIMEOUT - 1));
  assign w_hs0      = (r_state == S_FETCH) && !r_grant && req0_valid;
  assign w_hs1      = (r_state == S_FETCH) &&  r_grant && req1_valid;
  assign w_req_data = r_grant ? req1_data : req0_data;
  assign w_req_last = r_grant ? req1_last : req0_last;
  assign w_unused   = ^wbm_dat_i;

  assign req0_ready = w_hs0;
  assign req1_ready = w_hs1;
  assign wbm_addr   = r_addr;
  assign wbm_dat_o  = r_dat_o;
  assign wbm_we     = r_we;
  assign wbm_sel    = r_sel;
  assign wbm_stb    = r_stb;
  assign busy       = (r_state != S_IDLE);
  assign grant_id   = r_grant;
  assign err        = r_err;
  assign tx_count   = r_tx_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_gap_next <= S_IDLE;
      r_grant    <= 1'b0;
      r_prio     <= 1'b0;
      r_stb      <= 1'b0;
      r_we       <= 1'b0;
      r_sel      <= 4'h0;
      r_addr     <= 8'h00;
      r_dat_o    <= 32'h0;
      r_byte     <= 8'h00;
      r_last     <= 1'b0;
      r_err      <= 1'b0;
      r_tx_count <= 16'h0;
      r_tmo      <= '0;
    end else begin
      // A timeout in the same cycle as err_clr leaves err set.
      if (w_timeout)
        r_err <= 1'b1;
      else if (err_clr)
        r_err <= 1'b0;

      if (w_in_bus && !wbm_ack && !w_timeout)
        r_tmo <= r_tmo + TMO_W'(1);

      case (r_state)
        S_IDLE: begin
          if (req0_valid || req1_valid) begin
            if (r_prio)
              r_grant <= req1_valid ? 1'b1 : 1'b0;
            else
              r_grant <= req0_valid ? 1'b0 : 1'b1;
            r_state <= S_FETCH;
          end
        end

        S_FETCH: begin
          if (w_hs0 || w_hs1) begin
            r_byte  <= w_req_data;
            r_last  <= w_req_last;
            r_stb   <= 1'b1;
            r_we    <= 1'b0;
            r_addr  <= UART_STAT_ADDR;
            r_sel   <= 4'hF;
            r_tmo   <= '0;
            r_state <= S_POLL;
          end
        end

        S_POLL: begin
          if (w_timeout) begin
            r_stb   <= 1'b0;
            r_sel   <= 4'h0;
            r_prio  <= ~r_grant;
            r_state <= S_IDLE;
          end else if (w_ack) begin
            r_stb <= 1'b0;
            r_sel <= 4'h0;
            // WRITE opens with stb low, which doubles as the bus gap.
            if (wbm_dat_i[TX_RDY_BIT]) begin
              r_state <= S_WRITE;
            end else begin
              r_state    <= S_GAP;
              r_gap_next <= S_POLL;
            end
          end
        end

        S_WRITE: begin
          if (!r_stb) begin
            r_stb   <= 1'b1;
            r_we    <= 1'b1;
            r_addr  <= UART_DATA_ADDR;
            r_sel   <= 4'hF;
            r_dat_o <= {24'h0, r_byte};
            r_tmo   <= '0;
          end else if (w_timeout) begin
            r_stb   <= 1'b0;
            r_we    <= 1'b0;
            r_sel   <= 4'h0;
            r_prio  <= ~r_grant;
            r_state <= S_IDLE;
          end else if (w_ack) begin
            r_stb      <= 1'b0;
            r_we       <= 1'b0;
            r_sel      <= 4'h0;
            r_tx_count <= r_tx_count + 16'd1;
            r_state    <= S_GAP;
            if (r_last) begin
              r_prio     <= ~r_grant;
              r_gap_next <= S_IDLE;
            end else begin
              r_gap_next <= S_FETCH;
            end
          end
        end

        S_GAP: begin
          r_state <= r_gap_next;
          if (r_gap_next == S_POLL) begin
            r_stb  <= 1'b1;
            r_we   <= 1'b0;
            r_addr <= UART_STAT_ADDR;
            r_sel  <= 4'hF;
            r_tmo  <= '0;
          end
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_sched.sv
// Scoreboard bench for uart_tx_sched: expected Wishbone transactions are queued
// with the stimulus and a bus monitor checks each acked transfer against them.
module tb_uart_tx_sched;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req0_valid = 1'b0, req1_valid = 1'b0;
  logic [7:0]  req0_data = 8'h00, req1_data = 8'h00;
  logic        req0_last = 1'b0, req1_last = 1'b0;
  logic        req0_ready, req1_ready;
  logic [7:0]  wbm_addr;
  logic [31:0] wbm_dat_o;
  logic [31:0] wbm_dat_i = 32'hFFFF_FFFF;
  logic        wbm_we;
  logic [3:0]  wbm_sel;
  logic        wbm_stb;
  logic        wbm_ack = 1'b0;
  logic        busy, grant_id, err;
  logic        err_clr = 1'b0;
  logic [15:0] tx_count;

  uart_tx_sched dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_data(req0_data), .req0_last(req0_last), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_data(req1_data), .req1_last(req1_last), .req1_ready(req1_ready),
    .wbm_addr(wbm_addr), .wbm_dat_o(wbm_dat_o), .wbm_dat_i(wbm_dat_i), .wbm_we(wbm_we),
    .wbm_sel(wbm_sel), .wbm_stb(wbm_stb), .wbm_ack(wbm_ack),
    .busy(busy), .grant_id(grant_id), .err(err), .err_clr(err_clr), .tx_count(tx_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        we;
    logic [7:0]  addr;
    logic [31:0] dat;
  } txn_t;

  txn_t        expq[$];
  logic [8:0]  q0[$];
  logic [8:0]  q1[$];
  logic [31:0] stat_q[$];
  logic        hs0 = 1'b0, hs1 = 1'b0;
  logic        mute_wr = 1'b0;
  logic        gap_seen = 1'b1;
  int          n_cmp = 0;
  int          n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic exp_rd();
    expq.push_back('{we: 1'b0, addr: 8'h04, dat: 32'h0});
  endtask

  task automatic exp_wr(input logic [7:0] b);
    expq.push_back('{we: 1'b1, addr: 8'h00, dat: {24'h0, b}});
  endtask

  // Requester drivers: present the head of each queue, pop after a handshake.
  always @(posedge clk) begin
    if (req0_valid && req0_ready) hs0 = 1'b1;
    if (req1_valid && req1_ready) hs1 = 1'b1;
  end

  always @(negedge clk) begin
    logic [8:0] tmp;
    if (hs0) begin tmp = q0.pop_front(); hs0 = 1'b0; end
    if (hs1) begin tmp = q1.pop_front(); hs1 = 1'b0; end
    req0_valid = (q0.size() != 0);
    if (req0_valid) {req0_last, req0_data} = q0[0];
    req1_valid = (q1.size() != 0);
    if (req1_valid) {req1_last, req1_data} = q1[0];
  end

  // UART slave model: one-cycle ack; dat_i holds TX-ready junk outside ack.
  always @(negedge clk) begin
    if (wbm_ack) begin
      wbm_ack   = 1'b0;
      wbm_dat_i = 32'hFFFF_FFFF;
    end else if (wbm_stb && !(mute_wr && wbm_we)) begin
      wbm_ack = 1'b1;
      if (!wbm_we)
        wbm_dat_i = (stat_q.size() != 0) ? stat_q.pop_front() : 32'h0000_0002;
    end
  end

  // Bus monitor: each acked strobe is one completed transaction.
  always @(negedge clk) begin
    txn_t t;
    #1;
    if (!wbm_stb) begin
      gap_seen = 1'b1;
    end else if (wbm_ack) begin
      chk("stb_gap", gap_seen, 1'b1);
      gap_seen = 1'b0;
      if (expq.size() == 0) begin
        chk("unexpected_txn", {wbm_we, wbm_addr}, 32'h0);
      end else begin
        t = expq.pop_front();
        chk("txn_we", wbm_we, t.we);
        chk("txn_addr", wbm_addr, t.addr);
        chk("txn_sel", wbm_sel, 4'hF);
        if (t.we) chk("txn_dat", wbm_dat_o, t.dat);
      end
    end
  end

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_stb"}, wbm_stb, 1'b0);
    chk({tag, "_we"}, wbm_we, 1'b0);
    chk({tag, "_busy"}, busy, 1'b0);
    chk({tag, "_err"}, err, 1'b0);
    chk({tag, "_txcnt"}, tx_count, 16'h0);
    chk({tag, "_addr"}, wbm_addr, 8'h00);
    chk({tag, "_dato"}, wbm_dat_o, 32'h0);
    chk({tag, "_grant"}, grant_id, 1'b0);
    chk({tag, "_rdy"}, {req0_ready, req1_ready}, 2'b00);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic wait_done(input string nm);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      #3;
      if (expq.size() == 0 && q0.size() == 0 && q1.size() == 0 && !busy) begin
        ok = 1'b1;
        break;
      end
    end
    chk(nm, ok, 1'b1);
  endtask

  initial begin
    int n;
    bit seen;

    repeat (3) @(negedge clk);
    #1;
    chk_reset_outputs("rst");
    rst_n = 1'b1;

    // Single byte 0x55 from req0, UART ready on the first poll
    exp_rd(); exp_wr(8'h55);
    q0.push_back({1'b1, 8'h55});
    wait_done("t1_done");
    chk("t1_txcnt", tx_count, 16'd1);
    chk("t1_busy", busy, 1'b0);

    // Both valid from reset: req0 first, then req1; priority then back on req0
    do_reset();
    exp_rd(); exp_wr(8'hA0); exp_rd(); exp_wr(8'hB1);
    q0.push_back({1'b1, 8'hA0});
    q1.push_back({1'b1, 8'hB1});
    wait_done("t2a_done");
    exp_rd(); exp_wr(8'hA2); exp_rd(); exp_wr(8'hB3);
    q0.push_back({1'b1, 8'hA2});
    q1.push_back({1'b1, 8'hB3});
    wait_done("t2b_done");
    chk("t2_txcnt", tx_count, 16'd4);

    // Packet lock: "HI\n" from req0 completes before req1's byte
    exp_rd(); exp_wr(8'h48); exp_rd(); exp_wr(8'h49); exp_rd(); exp_wr(8'h0A);
    exp_rd(); exp_wr(8'h77);
    q1.push_back({1'b1, 8'h77});
    q0.push_back({1'b0, 8'h48});
    q0.push_back({1'b0, 8'h49});
    q0.push_back({1'b1, 8'h0A});
    wait_done("t3_done");
    chk("t3_txcnt", tx_count, 16'd8);

    // STATUS not ready twice (only bit 1 matters), then ready
    stat_q.push_back(32'h0000_0000);
    stat_q.push_back(32'hFFFF_FFFD);
    exp_rd(); exp_rd(); exp_rd(); exp_wr(8'h3C);
    q0.push_back({1'b1, 8'h3C});
    wait_done("t4_done");
    chk("t4_txcnt", tx_count, 16'd9);

    // DATA write never acked: 16 strobe cycles, err set (wins over err_clr)
    mute_wr = 1'b1;
    exp_rd();
    q0.push_back({1'b1, 8'h99});
    n = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      #2;
      if (wbm_stb && wbm_we) begin
        n++;
        if (n == 16) err_clr = 1'b1;
      end else if (n > 0) begin
        break;
      end
    end
    err_clr = 1'b0;
    chk("t5_stb_cycles", n, 16);
    chk("t5_stb_low", wbm_stb, 1'b0);
    chk("t5_err_set", err, 1'b1);
    chk("t5_txcnt", tx_count, 16'd9);
    chk("t5_idle", busy, 1'b0);
    chk("t5_expq", expq.size(), 0);
    @(negedge clk); err_clr = 1'b1;
    @(negedge clk); err_clr = 1'b0;
    #2;
    chk("t5_err_clr", err, 1'b0);

    // Reset asserted while the DATA write strobe is high
    exp_rd();
    q0.push_back({1'b1, 8'hC3});
    seen = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      #2;
      if (wbm_stb && wbm_we) begin seen = 1'b1; break; end
    end
    chk("t6_in_write", seen, 1'b1);
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("t6");
    @(negedge clk);
    rst_n   = 1'b1;
    mute_wr = 1'b0;
    chk("t6_expq", expq.size(), 0);

    // Recovery: lone req1 byte is granted even though req0 holds priority
    exp_rd(); exp_wr(8'h5A);
    q1.push_back({1'b1, 8'h5A});
    wait_done("t7_done");
    chk("t7_txcnt", tx_count, 16'd1);
    chk("t7_grant", grant_id, 1'b1);

    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
